mem_stage: RTL and testbench

Memory-access pipeline stage directly downstream of the execute stage.
- Registers the EX->MEM pipeline values and issues loads/stores on a req/gnt/rvalid data-memory bus.
- Performs byte-lane alignment, load extraction and sign/zero extension.
- Raises load/store misaligned traps and holds the pipeline via mem_busy_o until each access completes.
- Its outputs feed the write-back register and forwarding logic.

---
 rtl/mem_stage_pkg.sv | 33 +++
 rtl/mem_stage_if.sv | 21 ++
 rtl/mem_stage_lsu_align.sv | 38 +++
 rtl/mem_stage.sv | 213 +++++++++++++++++++++
 tb/tb_mem_stage.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the memory-access stage.
package mem_stage_pkg;

    typedef enum logic [1:0] {
        BYTE = 2'b00,
        HALF = 2'b01,
        WORD = 2'b10
    } data_type_t;

    typedef enum logic {
        X_REG = 1'b0,
        F_REG = 1'b1
    } reg_bank_mux_t;

    typedef enum logic [1:0] {
        IDLE        = 2'b00,
        WAIT_RVALID = 2'b01,
        DONE        = 2'b10
    } mem_state_t;

    localparam logic [4:0] EXC_LOAD_MISALIGNED  = 5'd4;
    localparam logic [4:0] EXC_STORE_MISALIGNED = 5'd6;

    // Natural alignment check on the low address bits.
    function automatic logic is_misaligned(input data_type_t dt, input logic [1:0] lo);
        case (dt)
            HALF:    return lo[0];
            WORD:    return lo != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory request/grant/rvalid bus.
interface mem_stage_if;
    logic        req;
    logic        gnt;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (
        output req, we, be, addr, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, be, addr, wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/mem_stage_lsu_align.sv
// Byte-lane alignment: store enables/data replication and load extraction/extension.
module mem_stage_lsu_align
    import mem_stage_pkg::*;
(
    input  data_type_t  dtype_i,
    input  logic [1:0]  addr_lo_i,
    input  logic        sign_ext_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] load_data_o
);

    logic [31:0] shifted;

    // Lane selection per access width; loads are shifted down then extended.
    always_comb begin
        shifted     = rdata_i >> {addr_lo_i, 3'b000};
        be_o        = 4'b1111;
        wdata_o     = wdata_i;
        load_data_o = shifted;
        case (dtype_i)
            BYTE: begin
                be_o        = 4'b0001 << addr_lo_i;
                wdata_o     = {4{wdata_i[7:0]}};
                load_data_o = {{24{sign_ext_i & shifted[7]}}, shifted[7:0]};
            end
            HALF: begin
                be_o        = 4'b0011 << {addr_lo_i[1], 1'b0};
                wdata_o     = {2{wdata_i[15:0]}};
                load_data_o = {{16{sign_ext_i & shifted[15]}}, shifted[15:0]};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: EX->MEM register, data-memory sequencing,
// misaligned traps and the hold towards upstream stages.
//
// state       | meaning
// ------------+----------------------------------------------------------
// IDLE        | no bus transaction in flight; request issued from here
// WAIT_RVALID | load granted, waiting for read data
// DONE        | read data captured in rdata_q while downstream stalls
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter bit ISA_F = 1'b0
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [4:0]    rd_addr_ex_i,
    input  reg_bank_mux_t rd_dst_bank_ex_i,
    input  logic [31:0]   alu_result_ex_i,
    input  logic          mem_wen_ex_i,
    input  data_type_t    mem_data_type_ex_i,
    input  logic          mem_sign_extend_ex_i,
    input  logic [31:0]   mem_wdata_ex_i,
    input  logic          reg_alu_wen_ex_i,
    input  logic          reg_mem_wen_ex_i,
    input  logic          valid_ex_i,
    input  logic          stall_mem_i,
    input  logic          flush_mem_i,
    mem_stage_if.master   dmem,
    output logic [4:0]    rd_addr_mem_o,
    output reg_bank_mux_t rd_dst_bank_mem_o,
    output logic          reg_wen_mem_o,
    output logic [31:0]   rd_wdata_mem_o,
    output logic          valid_mem_o,
    output logic          mem_busy_o,
    output logic          trap_mem_o,
    output logic [4:0]    trap_cause_mem_o,
    output logic [31:0]   trap_tval_mem_o
);

    logic          valid_q, valid_d;
    logic [4:0]    rd_addr_q, rd_addr_d;
    reg_bank_mux_t bank_q, bank_d;
    logic [31:0]   alu_q, alu_d;
    logic          mem_wen_q, mem_wen_d;
    data_type_t    dtype_q, dtype_d;
    logic          sign_q, sign_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          reg_alu_wen_q, reg_alu_wen_d;
    logic          reg_mem_wen_q, reg_mem_wen_d;
    mem_state_t    state_q, state_d;
    logic          flushed_q, flushed_d;
    logic [31:0]   rdata_q, rdata_d;

    logic          mem_op;
    logic          misaligned;
    logic          req;
    logic          complete;
    logic          busy;
    logic          use_rdata_q;
    logic          kill;
    logic          trap_evt;
    logic          load_en;
    logic          keep;
    logic [3:0]    be_al;
    logic [31:0]   wdata_al;
    logic [31:0]   load_data;

    mem_stage_lsu_align u_lsu_align (
        .dtype_i     (dtype_q),
        .addr_lo_i   (alu_q[1:0]),
        .sign_ext_i  (sign_q),
        .wdata_i     (wdata_q),
        .rdata_i     (use_rdata_q ? rdata_q : dmem.rdata),
        .be_o        (be_al),
        .wdata_o     (wdata_al),
        .load_data_o (load_data)
    );

    // Access sequencing: request issue, completion and the next bus state.
    always_comb begin
        state_d     = state_q;
        flushed_d   = flushed_q;
        rdata_d     = rdata_q;
        complete    = 1'b0;
        use_rdata_q = 1'b0;
        mem_op      = valid_q && (mem_wen_q || reg_mem_wen_q);
        misaligned  = is_misaligned(dtype_q, alu_q[1:0]);
        // Flush withdraws a not-yet-granted request in the same cycle.
        req         = (state_q == IDLE) && mem_op && !misaligned
                      && !stall_mem_i && !flush_mem_i;
        case (state_q)
            IDLE: begin
                if (valid_q && !stall_mem_i) begin
                    if (!mem_op || misaligned) begin
                        complete = 1'b1;
                    end else if (req && dmem.gnt) begin
                        if (mem_wen_q) complete = 1'b1;
                        else           state_d  = WAIT_RVALID;
                    end
                end
            end
            WAIT_RVALID: begin
                if (flush_mem_i) flushed_d = 1'b1;
                if (dmem.rvalid) begin
                    if (!stall_mem_i) begin
                        complete  = 1'b1;
                        flushed_d = 1'b0;
                        state_d   = IDLE;
                    end else begin
                        rdata_d = dmem.rdata;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                use_rdata_q = 1'b1;
                if (flush_mem_i) flushed_d = 1'b1;
                if (!stall_mem_i) begin
                    complete  = 1'b1;
                    flushed_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy = mem_op && !complete;
    end

    // EX->MEM register next value; a flush loads a bubble or kills a waiting op.
    always_comb begin
        valid_d       = valid_q;
        rd_addr_d     = rd_addr_q;
        bank_d        = bank_q;
        alu_d         = alu_q;
        mem_wen_d     = mem_wen_q;
        dtype_d       = dtype_q;
        sign_d        = sign_q;
        wdata_d       = wdata_q;
        reg_alu_wen_d = reg_alu_wen_q;
        reg_mem_wen_d = reg_mem_wen_q;
        load_en       = !stall_mem_i && !busy;
        keep          = valid_ex_i && !flush_mem_i;
        if (load_en) begin
            valid_d       = keep;
            rd_addr_d     = rd_addr_ex_i;
            bank_d        = rd_dst_bank_ex_i;
            alu_d         = alu_result_ex_i;
            mem_wen_d     = mem_wen_ex_i && keep;
            dtype_d       = mem_data_type_ex_i;
            sign_d        = mem_sign_extend_ex_i;
            wdata_d       = mem_wdata_ex_i;
            reg_alu_wen_d = reg_alu_wen_ex_i && keep;
            reg_mem_wen_d = reg_mem_wen_ex_i && keep;
        end else if (flush_mem_i && state_q == IDLE) begin
            valid_d = 1'b0;
        end
    end

    // State and pipeline registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q       <= 1'b0;
            rd_addr_q     <= '0;
            bank_q        <= X_REG;
            alu_q         <= '0;
            mem_wen_q     <= 1'b0;
            dtype_q       <= BYTE;
            sign_q        <= 1'b0;
            wdata_q       <= '0;
            reg_alu_wen_q <= 1'b0;
            reg_mem_wen_q <= 1'b0;
            state_q       <= IDLE;
            flushed_q     <= 1'b0;
            rdata_q       <= '0;
        end else begin
            valid_q       <= valid_d;
            rd_addr_q     <= rd_addr_d;
            bank_q        <= bank_d;
            alu_q         <= alu_d;
            mem_wen_q     <= mem_wen_d;
            dtype_q       <= dtype_d;
            sign_q        <= sign_d;
            wdata_q       <= wdata_d;
            reg_alu_wen_q <= reg_alu_wen_d;
            reg_mem_wen_q <= reg_mem_wen_d;
            state_q       <= state_d;
            flushed_q     <= flushed_d;
            rdata_q       <= rdata_d;
        end
    end

    // Bus and write-back outputs; everything idles at zero when not active.
    always_comb begin
        dmem.req          = req;
        dmem.we           = req && mem_wen_q;
        dmem.be           = req ? be_al : 4'b0000;
        dmem.addr         = req ? {alu_q[31:2], 2'b00} : 32'd0;
        dmem.wdata        = req ? wdata_al : 32'd0;
        kill              = flush_mem_i || flushed_q;
        trap_evt          = complete && mem_op && misaligned;
        valid_mem_o       = complete && !kill && !trap_evt;
        trap_mem_o        = trap_evt && !kill;
        trap_cause_mem_o  = trap_mem_o ? (mem_wen_q ? EXC_STORE_MISALIGNED : EXC_LOAD_MISALIGNED)
                                       : 5'd0;
        trap_tval_mem_o   = trap_mem_o ? alu_q : 32'd0;
        reg_wen_mem_o     = valid_mem_o && (reg_alu_wen_q || reg_mem_wen_q);
        rd_wdata_mem_o    = valid_mem_o ? (reg_mem_wen_q ? load_data : alu_q) : 32'd0;
        rd_addr_mem_o     = rd_addr_q;
        rd_dst_bank_mem_o = ISA_F ? bank_q : X_REG;
        mem_busy_o        = busy;
    end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage with a transaction-level reference model.
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic          clk = 1'b0;
    logic          rst;
    logic [4:0]    rd_addr_ex;
    reg_bank_mux_t bank_ex;
    logic [31:0]   alu_ex;
    logic          mem_wen_ex;
    data_type_t    dtype_ex;
    logic          sign_ex;
    logic [31:0]   wdata_ex;
    logic          reg_alu_wen_ex, reg_mem_wen_ex, valid_ex, stall, flush;
    logic [4:0]    rd_addr_mem;
    reg_bank_mux_t bank_mem;
    logic          reg_wen_mem, valid_mem, busy, trap;
    logic [31:0]   rd_wdata_mem, tval;
    logic [4:0]    cause;

    int n_checks = 0;
    int n_errors = 0;
    int req_cnt, busy_cnt;

    mem_stage_if dmem_bus();

    mem_stage #(.ISA_F(1'b0)) dut (
        .clk_i                (clk),
        .rst_i                (rst),
        .rd_addr_ex_i         (rd_addr_ex),
        .rd_dst_bank_ex_i     (bank_ex),
        .alu_result_ex_i      (alu_ex),
        .mem_wen_ex_i         (mem_wen_ex),
        .mem_data_type_ex_i   (dtype_ex),
        .mem_sign_extend_ex_i (sign_ex),
        .mem_wdata_ex_i       (wdata_ex),
        .reg_alu_wen_ex_i     (reg_alu_wen_ex),
        .reg_mem_wen_ex_i     (reg_mem_wen_ex),
        .valid_ex_i           (valid_ex),
        .stall_mem_i          (stall),
        .flush_mem_i          (flush),
        .dmem                 (dmem_bus),
        .rd_addr_mem_o        (rd_addr_mem),
        .rd_dst_bank_mem_o    (bank_mem),
        .reg_wen_mem_o        (reg_wen_mem),
        .rd_wdata_mem_o       (rd_wdata_mem),
        .valid_mem_o          (valid_mem),
        .mem_busy_o           (busy),
        .trap_mem_o           (trap),
        .trap_cause_mem_o     (cause),
        .trap_tval_mem_o      (tval)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int size_of(input data_type_t dt);
        case (dt)
            BYTE:    return 1;
            HALF:    return 2;
            default: return 4;
        endcase
    endfunction

    function automatic logic [3:0] model_be(input data_type_t dt, input logic [31:0] addr);
        int sz = size_of(dt);
        int m  = ((1 << sz) - 1) << (addr % 4);
        return 4'(m);
    endfunction

    function automatic logic [31:0] model_wdata(input data_type_t dt, input logic [31:0] wd);
        logic [31:0] r;
        int sz = size_of(dt);
        for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % sz) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] model_load(input data_type_t dt, input logic [31:0] addr,
                                               input logic sgn, input logic [31:0] rd);
        int sz = size_of(dt);
        logic [31:0] mask;
        logic [31:0] v;
        v    = rd >> (8 * (addr % 4));
        mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * sz)) - 32'd1);
        v    = v & mask;
        if (sgn && sz < 4 && v[8*sz-1]) v = v | ~mask;
        return v;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic drive_ex(input int kind, input data_type_t dt, input logic [31:0] addr,
                            input logic sgn, input logic [31:0] wd, input logic [4:0] rdst);
        valid_ex       = 1'b1;
        rd_addr_ex     = rdst;
        bank_ex        = reg_bank_mux_t'($urandom_range(0, 1));
        alu_ex         = addr;
        mem_wen_ex     = (kind == 2);
        dtype_ex       = dt;
        sign_ex        = sgn;
        wdata_ex       = wd;
        reg_alu_wen_ex = (kind == 0);
        reg_mem_wen_ex = (kind == 1);
    endtask

    task automatic clear_ex();
        valid_ex       = 1'b0;
        mem_wen_ex     = 1'b0;
        reg_alu_wen_ex = 1'b0;
        reg_mem_wen_ex = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check_val({tag, "_req"},   32'(dmem_bus.req), 0);
        check_val({tag, "_we"},    32'(dmem_bus.we), 0);
        check_val({tag, "_be"},    32'(dmem_bus.be), 0);
        check_val({tag, "_addr"},  dmem_bus.addr, 0);
        check_val({tag, "_wdata"}, dmem_bus.wdata, 0);
        check_val({tag, "_valid"}, 32'(valid_mem), 0);
        check_val({tag, "_rwen"},  32'(reg_wen_mem), 0);
        check_val({tag, "_rdat"},  rd_wdata_mem, 0);
        check_val({tag, "_rda"},   32'(rd_addr_mem), 0);
        check_val({tag, "_bank"},  32'(bank_mem), 32'(X_REG));
        check_val({tag, "_busy"},  32'(busy), 0);
        check_val({tag, "_trap"},  32'(trap), 0);
        check_val({tag, "_cause"}, 32'(cause), 0);
        check_val({tag, "_tval"},  tval, 0);
    endtask

    // kind: 0 = ALU op, 1 = load, 2 = store.
    // smode: 0 = no stall, 1 = random stall, 2 = stall for 3 cycles starting at rvalid.
    task automatic run_op(input string tag, input int kind, input data_type_t dt,
                          input logic [31:0] addr, input logic sgn, input logic [31:0] wd,
                          input logic [31:0] rd, input int gdly, input int rdly,
                          input int smode, output int n_req, output int n_busy);
        int   sz = size_of(dt);
        bit   mis = (kind != 0) && ((addr % sz) != 0);
        bit   granted = 0, rv_done = 0, done = 0, seen_req = 0;
        int   since_gnt = 0, stall_left = 0;
        logic [4:0] rdst = 5'($urandom_range(1, 31));
        n_req  = 0;
        n_busy = 0;
        @(negedge clk);
        drive_ex(kind, dt, addr, sgn, wd, rdst);
        stall = 1'b0; flush = 1'b0;
        dmem_bus.gnt = 1'b0; dmem_bus.rvalid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        clear_ex();
        for (int cyc = 0; cyc < 60 && !done; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (granted) since_gnt++;
            stall = (smode == 1) ? ($urandom_range(0, 3) == 0) : (stall_left > 0);
            dmem_bus.gnt    = !granted && (n_req >= gdly);
            dmem_bus.rvalid = granted && !rv_done && (since_gnt >= rdly);
            if (dmem_bus.rvalid && smode == 2) begin
                stall_left = 3;
                stall      = 1'b1;
            end
            dmem_bus.rdata = dmem_bus.rvalid ? rd : $urandom();
            #1;
            n_busy += int'(busy);
            if (dmem_bus.req) begin
                if (!seen_req) begin
                    seen_req = 1;
                    check_val({tag, "_addr"}, dmem_bus.addr, {addr[31:2], 2'b00});
                    check_val({tag, "_be"},   32'(dmem_bus.be), 32'(model_be(dt, addr)));
                    check_val({tag, "_we"},   32'(dmem_bus.we), 32'(kind == 2));
                    if (kind == 2) check_val({tag, "_wdata"}, dmem_bus.wdata, model_wdata(dt, wd));
                end
                n_req++;
                if (dmem_bus.gnt) granted = 1;
            end
            if (dmem_bus.rvalid) rv_done = 1;
            if (stall_left > 0) stall_left--;
            if (valid_mem || trap) begin
                done = 1;
                check_val({tag, "_busy_end"}, 32'(busy), 0);
                if (mis) begin
                    check_val({tag, "_trap"},  32'(trap), 1);
                    check_val({tag, "_cause"}, 32'(cause), (kind == 2) ? 32'd6 : 32'd4);
                    check_val({tag, "_tval"},  tval, addr);
                    check_val({tag, "_valid"}, 32'(valid_mem), 0);
                    check_val({tag, "_rwen"},  32'(reg_wen_mem), 0);
                    check_val({tag, "_noreq"}, 32'(n_req), 0);
                end else begin
                    check_val({tag, "_trap"}, 32'(trap), 0);
                    check_val({tag, "_rwen"}, 32'(reg_wen_mem), 32'(kind != 2));
                    check_val({tag, "_rda"},  32'(rd_addr_mem), 32'(rdst));
                    check_val({tag, "_bank"}, 32'(bank_mem), 32'(X_REG));
                    if (kind == 0) check_val({tag, "_alu"}, rd_wdata_mem, addr);
                    if (kind == 1) check_val({tag, "_load"}, rd_wdata_mem, model_load(dt, addr, sgn, rd));
                    if (kind == 2) check_val({tag, "_st_gnt"}, 32'(dmem_bus.req && dmem_bus.gnt), 1);
                end
            end
            @(posedge clk);
        end
        if (!done) check_val({tag, "_timeout"}, 0, 1);
        @(negedge clk);
        stall = 1'b0; dmem_bus.gnt = 1'b0; dmem_bus.rvalid = 1'b0;
        #1;
        check_val({tag, "_single"}, 32'(valid_mem || trap), 0);
        check_val({tag, "_idle_busy"}, 32'(busy), 0);
    endtask

    // Issue an aligned load that is granted immediately; returns in WAIT_RVALID.
    task automatic issue_granted_load(input string tag, input logic [31:0] addr);
        @(negedge clk);
        drive_ex(1, WORD, addr, 1'b0, 32'd0, 5'd9);
        stall = 1'b0; flush = 1'b0; dmem_bus.gnt = 1'b1; dmem_bus.rvalid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        clear_ex();
        #1;
        check_val({tag, "_req"}, 32'(dmem_bus.req), 1);
        @(posedge clk);
        @(negedge clk);
        dmem_bus.gnt = 1'b0;
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0;
        rd_addr_ex = '0; bank_ex = X_REG; alu_ex = '0; dtype_ex = BYTE;
        sign_ex = 1'b0; wdata_ex = '0; clear_ex();
        dmem_bus.gnt = 1'b0; dmem_bus.rvalid = 1'b0; dmem_bus.rdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_idle_outputs("reset");

        // lb / lbu with the sign byte in the top lane
        run_op("lb",  1, BYTE, 32'h1003, 1'b1, 0, 32'h8000_0000, 0, 1, 0, req_cnt, busy_cnt);
        run_op("lbu", 1, BYTE, 32'h1003, 1'b0, 0, 32'h8000_0000, 0, 1, 0, req_cnt, busy_cnt);

        // sh upper half, immediate grant
        run_op("sh", 2, HALF, 32'h2002, 1'b0, 32'h0000_BEEF, 0, 0, 1, 0, req_cnt, busy_cnt);
        check_val("sh_req_cycles", 32'(req_cnt), 1);

        // lw with slow grant and slow rvalid
        run_op("lw_slow", 1, WORD, 32'h3000, 1'b0, 0, 32'h1234_5678, 3, 2, 0, req_cnt, busy_cnt);
        check_val("lw_slow_req_cycles", 32'(req_cnt), 4);
        check_val("lw_slow_busy_cycles", 32'(busy_cnt), 5);

        // misaligned word load and store
        run_op("lw_mis", 1, WORD, 32'h1002, 1'b0, 0, 0, 0, 1, 0, req_cnt, busy_cnt);
        check_val("lw_mis_busy_cycles", 32'(busy_cnt), 0);
        run_op("sh_mis", 2, HALF, 32'h1001, 1'b0, 32'h55AA, 0, 0, 1, 0, req_cnt, busy_cnt);

        // flush while waiting for read data
        issue_granted_load("flush", 32'h4000);
        flush = 1'b1;
        #1;
        check_val("flush_wait_valid", 32'(valid_mem), 0);
        check_val("flush_wait_busy", 32'(busy), 1);
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0; dmem_bus.rvalid = 1'b1; dmem_bus.rdata = 32'hDEAD_BEEF;
        #1;
        check_val("flush_rv_valid", 32'(valid_mem), 0);
        check_val("flush_rv_rwen", 32'(reg_wen_mem), 0);
        check_val("flush_rv_busy", 32'(busy), 0);
        @(posedge clk);
        @(negedge clk);
        dmem_bus.rvalid = 1'b0;
        #1;
        check_val("flush_after_req", 32'(dmem_bus.req), 0);
        check_val("flush_after_valid", 32'(valid_mem), 0);
        run_op("post_flush", 1, WORD, 32'h4004, 1'b0, 0, 32'h0BAD_F00D, 0, 1, 0, req_cnt, busy_cnt);
        check_val("post_flush_req_cycles", 32'(req_cnt), 1);

        // stall across rvalid: data held in DONE, one completion after release
        run_op("stall_done", 1, WORD, 32'h5000, 1'b0, 0, 32'hCAFE_BABE, 0, 1, 2, req_cnt, busy_cnt);
        check_val("stall_done_busy_cycles", 32'(busy_cnt), 4);

        // reset in the middle of a load
        issue_granted_load("rst_mid", 32'h6000);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_idle_outputs("rst_mid");
        run_op("post_rst", 0, WORD, 32'h0000_0777, 1'b0, 0, 0, 0, 1, 0, req_cnt, busy_cnt);

        // randomized mix
        for (int n = 0; n < 150; n++) begin
            int         kind = $urandom_range(0, 2);
            data_type_t dt   = data_type_t'($urandom_range(0, 2));
            run_op("rnd", kind, dt, $urandom(), 1'($urandom_range(0, 1)), $urandom(), $urandom(),
                   $urandom_range(0, 3), $urandom_range(1, 3), $urandom_range(0, 1),
                   req_cnt, busy_cnt);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
